// File: rtl/pinball_pkg.sv
// Shared types and constants for the pinball game-flow controller.
// Holds the game phase encoding and the BCD score limits.
package pinball_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READY  = 3'd1,
        PLAY   = 3'd2,
        PAUSED = 3'd3,
        LOST   = 3'd4,
        OVER   = 3'd5
    } game_state_t;

    localparam int          BCD_DIGITS = 4;
    localparam logic [15:0] BCD_MAX    = 16'h9999;

endpackage

// File: rtl/bcd_score_counter.sv
// Four-digit BCD score accumulator with ripple carry and saturation at 9999.
// Latency: one cycle from add_en/clear to score_bcd.
// Backpressure: none; every add_en is applied, clear has priority over add.
module bcd_score_counter
    import pinball_pkg::*;
(
    input  logic        clk,
    input  logic        resetN,
    input  logic        clear,
    input  logic        add_en,
    input  logic [3:0]  add_val,
    output logic [15:0] score_bcd
);

    logic [15:0] sum_bcd;
    logic [15:0] next_bcd;
    logic [4:0]  dsum;
    logic [4:0]  dadj;
    logic        carry;

    // add_val only enters the ones digit; higher digits see just the carry
    always_comb begin
        sum_bcd = '0;
        carry   = 1'b0;
        dsum    = '0;
        dadj    = '0;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            dsum = {1'b0, score_bcd[4*i +: 4]} + {4'd0, carry};
            if (i == 0) begin
                dsum = dsum + {1'b0, add_val};
            end
            dadj  = dsum - 5'd10;
            carry = (dsum > 5'd9);
            sum_bcd[4*i +: 4] = carry ? dadj[3:0] : dsum[3:0];
        end
        next_bcd = carry ? BCD_MAX : sum_bcd;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            score_bcd <= '0;
        end else if (clear) begin
            score_bcd <= '0;
        end else if (add_en) begin
            score_bcd <= next_bcd;
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Pinball game-flow FSM: serve/play/pause/ball-lost/game-over, lives and score.
// Latency: input rise acts on the next edge; reset_level is a same-cycle Mealy pulse.
// Backpressure: none; key/collision events are edge-detected and never queued.
module game_sequencer
    import pinball_pkg::*;
#(
    parameter int LIVES             = 3,
    parameter int LOST_DELAY_FRAMES = 60,
    parameter int HIT_POINTS        = 1
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        key5IsPressed,
    input  logic        keyPIsPressed,
    input  logic        collisionSmileyBorderBottom,
    input  logic        collisionSmileyObstacle,
    output logic        pause,
    output logic        reset_level,
    output logic [2:0]  lives,
    output logic [15:0] score_bcd,
    output logic        game_over,
    output logic [2:0]  state_code
);

    localparam logic [2:0] LIVES_INIT   = 3'(LIVES);
    localparam logic [7:0] LOST_CNT_END = 8'(LOST_DELAY_FRAMES);
    localparam logic [3:0] HIT_VAL      = 4'(HIT_POINTS);

    game_state_t state;
    game_state_t state_nxt;

    logic key5_q, keyp_q, bottom_q, obst_q;
    logic key5_ev, keyp_ev, bottom_ev, obst_ev;
    logic [7:0] lost_cnt;
    logic hit_this_frame;
    logic score_clear, score_add;
    logic lives_load, lives_dec;
    logic cnt_clr, cnt_inc;

    assign key5_ev   = key5IsPressed               & ~key5_q;
    assign keyp_ev   = keyPIsPressed               & ~keyp_q;
    assign bottom_ev = collisionSmileyBorderBottom & ~bottom_q;
    assign obst_ev   = collisionSmileyObstacle     & ~obst_q;

    // only the first obstacle edge in a frame scores, so a ball resting on an obstacle counts once
    assign score_add = (state == PLAY) & obst_ev & ~hit_this_frame;

    always_comb begin
        state_nxt   = state;
        reset_level = 1'b0;
        score_clear = 1'b0;
        lives_load  = 1'b0;
        lives_dec   = 1'b0;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        case (state)
            IDLE: begin
                if (key5_ev) begin
                    reset_level = 1'b1;
                    score_clear = 1'b1;
                    lives_load  = 1'b1;
                    state_nxt   = READY;
                end
            end
            READY: begin
                if (key5_ev) state_nxt = PLAY;
            end
            PLAY: begin
                if (bottom_ev) begin
                    lives_dec = 1'b1;
                    cnt_clr   = 1'b1;
                    state_nxt = LOST;
                end else if (keyp_ev) begin
                    state_nxt = PAUSED;
                end
            end
            PAUSED: begin
                if (keyp_ev) state_nxt = PLAY;
            end
            LOST: begin
                if (lost_cnt == LOST_CNT_END) begin
                    if (lives == 3'd0) begin
                        state_nxt = OVER;
                    end else begin
                        reset_level = 1'b1;
                        state_nxt   = READY;
                    end
                end else if (startOfFrame) begin
                    cnt_inc = 1'b1;
                end
            end
            OVER: begin
                if (key5_ev) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign pause      = (state != PLAY);
    assign game_over  = (state == OVER);
    assign state_code = state;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state          <= IDLE;
            key5_q         <= 1'b0;
            keyp_q         <= 1'b0;
            bottom_q       <= 1'b0;
            obst_q         <= 1'b0;
            lives          <= LIVES_INIT;
            lost_cnt       <= '0;
            hit_this_frame <= 1'b0;
        end else begin
            state    <= state_nxt;
            key5_q   <= key5IsPressed;
            keyp_q   <= keyPIsPressed;
            bottom_q <= collisionSmileyBorderBottom;
            obst_q   <= collisionSmileyObstacle;
            if (lives_load) begin
                lives <= LIVES_INIT;
            end else if (lives_dec) begin
                lives <= lives - 3'd1;
            end
            if (cnt_clr) begin
                lost_cnt <= '0;
            end else if (cnt_inc) begin
                lost_cnt <= lost_cnt + 8'd1;
            end
            if (score_add) begin
                hit_this_frame <= 1'b1;
            end else if (startOfFrame) begin
                hit_this_frame <= 1'b0;
            end
        end
    end

    bcd_score_counter u_score (
        .clk       (clk),
        .resetN    (resetN),
        .clear     (score_clear),
        .add_en    (score_add),
        .add_val   (HIT_VAL),
        .score_bcd (score_bcd)
    );

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: three instances share stimulus (1, 5 and 9 points per hit)
// so BCD carry and saturation are reached quickly alongside the game-flow checks.
module tb_game_sequencer;

    logic clk    = 1'b0;
    logic resetN = 1'b0;
    logic sof = 1'b0, k5 = 1'b0, kp = 1'b0, bot = 1'b0, obs = 1'b0;

    logic        pause0, rl0, go0;
    logic [2:0]  lives0, sc0;
    logic [15:0] score0;
    logic        pause5, rl5, go5;
    logic [2:0]  lives5, sc5;
    logic [15:0] score5;
    logic        pause9, rl9, go9;
    logic [2:0]  lives9, sc9;
    logic [15:0] score9;

    typedef struct packed {
        logic [15:0] s0;
        logic [15:0] s5;
        logic [15:0] s9;
    } exp_t;

    exp_t sb[$];
    int   tests_run = 0;
    int   fails     = 0;
    int   hits      = 0;

    always #5 clk = ~clk;

    game_sequencer #(.LIVES(3), .LOST_DELAY_FRAMES(2), .HIT_POINTS(1)) u0 (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .key5IsPressed(k5),
        .keyPIsPressed(kp), .collisionSmileyBorderBottom(bot), .collisionSmileyObstacle(obs),
        .pause(pause0), .reset_level(rl0), .lives(lives0), .score_bcd(score0),
        .game_over(go0), .state_code(sc0));

    game_sequencer #(.LIVES(3), .LOST_DELAY_FRAMES(2), .HIT_POINTS(5)) u5 (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .key5IsPressed(k5),
        .keyPIsPressed(kp), .collisionSmileyBorderBottom(bot), .collisionSmileyObstacle(obs),
        .pause(pause5), .reset_level(rl5), .lives(lives5), .score_bcd(score5),
        .game_over(go5), .state_code(sc5));

    game_sequencer #(.LIVES(3), .LOST_DELAY_FRAMES(2), .HIT_POINTS(9)) u9 (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .key5IsPressed(k5),
        .keyPIsPressed(kp), .collisionSmileyBorderBottom(bot), .collisionSmileyObstacle(obs),
        .pause(pause9), .reset_level(rl9), .lives(lives9), .score_bcd(score9),
        .game_over(go9), .state_code(sc9));

    function automatic logic [15:0] bcd_of(input int v);
        int c;
        c = (v > 9999) ? 9999 : v;
        return {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
    endfunction

    task automatic push_exp();
        exp_t e;
        e.s0 = bcd_of(hits);
        e.s5 = bcd_of(hits * 5);
        e.s9 = bcd_of(hits * 9);
        sb.push_back(e);
    endtask

    // one cycle: inputs change just after the falling edge, outputs are read 2 ns later
    task automatic drive(input logic k, input logic p, input logic b, input logic o, input logic s);
        @(negedge clk);
        k5 = k; kp = p; bot = b; obs = o; sof = s;
        #2;
    endtask

    task automatic do_hit(input bit chk);
        drive(0, 0, 0, 1, 0);
        hits++;
        if (chk) push_exp();
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1);
    endtask

    // bottom hit, then two frames of LOST delay; counts reset_level pulses seen
    task automatic lose_ball(output int pulses);
        pulses = 0;
        drive(0, 0, 1, 0, 0); pulses += int'(rl0);
        drive(0, 0, 0, 0, 0); pulses += int'(rl0);
        drive(0, 0, 0, 0, 1); pulses += int'(rl0);
        drive(0, 0, 0, 0, 0); pulses += int'(rl0);
        drive(0, 0, 0, 0, 1); pulses += int'(rl0);
        drive(0, 0, 0, 0, 0); pulses += int'(rl0);
        drive(0, 0, 0, 0, 0); pulses += int'(rl0);
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        tests_run++;
        if ({sc0, pause0, rl0, lives0, go0, score0} !== {3'd0, 1'b1, 1'b0, 3'd3, 1'b0, 16'h0}) begin
            fails++;
            $display("FAIL reset_values got st=%0d p=%b rl=%b lv=%0d go=%b sc=%h exp st=0 p=1 rl=0 lv=3 go=0 sc=0000",
                     sc0, pause0, rl0, lives0, go0, score0);
        end
        @(negedge clk);
        resetN = 1'b1;
    endtask

    task automatic test_start();
        int pulses;
        pulses = 0;
        drive(1, 0, 0, 0, 0); pulses += int'(rl0);
        drive(0, 0, 0, 0, 0); pulses += int'(rl0);
        drive(0, 0, 0, 0, 0); pulses += int'(rl0);
        drive(0, 0, 0, 0, 0); pulses += int'(rl0);
        tests_run++;
        if (pulses != 1) begin
            fails++;
            $display("FAIL start_reset_level_pulse got %0d cycles exp 1", pulses);
        end
        tests_run++;
        if ({sc0, pause0, lives0, score0, go0} !== {3'd1, 1'b1, 3'd3, 16'h0, 1'b0}) begin
            fails++;
            $display("FAIL start_ready got st=%0d p=%b lv=%0d sc=%h go=%b exp st=1 p=1 lv=3 sc=0000 go=0",
                     sc0, pause0, lives0, score0, go0);
        end
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        tests_run++;
        if ({sc0, pause0, rl0} !== {3'd2, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL start_play got st=%0d p=%b rl=%b exp st=2 p=0 rl=0", sc0, pause0, rl0);
        end
    endtask

    task automatic test_scoring();
        exp_t e;
        // two rising edges in one frame, then obstacle held across two more frames
        drive(0, 0, 0, 1, 0);
        hits++;
        push_exp();
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 1);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 1);
        drive(0, 0, 0, 1, 0);
        e = sb.pop_front();
        tests_run++;
        if ({score0, score5, score9} !== e) begin
            fails++;
            $display("FAIL one_hit_per_frame got %h/%h/%h exp %h/%h/%h", score0, score5, score9, e.s0, e.s5, e.s9);
        end
        drive(0, 0, 0, 0, 0);
        for (int n = 2; n <= 2001; n++) begin
            do_hit(n == 2 || n == 199 || n == 200 || n == 1110 || n == 1111 ||
                   n == 1112 || n == 1999 || n == 2000 || n == 2001);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                tests_run++;
                if ({score0, score5, score9} !== e) begin
                    fails++;
                    $display("FAIL score_after_%0d_hits got %h/%h/%h exp %h/%h/%h",
                             n, score0, score5, score9, e.s0, e.s5, e.s9);
                end
            end
        end
    endtask

    task automatic test_ball_lost();
        exp_t e;
        logic [5:0] rl_seq;
        drive(0, 0, 1, 1, 0);
        hits++;
        push_exp();
        drive(0, 0, 0, 0, 0);
        tests_run++;
        if ({sc0, lives0, pause0, rl0} !== {3'd4, 3'd2, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL lost_entry got st=%0d lv=%0d p=%b rl=%b exp st=4 lv=2 p=1 rl=0", sc0, lives0, pause0, rl0);
        end
        e = sb.pop_front();
        tests_run++;
        if ({score0, score5, score9} !== e) begin
            fails++;
            $display("FAIL hit_with_bottom got %h/%h/%h exp %h/%h/%h", score0, score5, score9, e.s0, e.s5, e.s9);
        end
        rl_seq = '0;
        drive(0, 0, 0, 0, 0); rl_seq = {rl_seq[4:0], rl0};
        drive(0, 0, 0, 0, 1); rl_seq = {rl_seq[4:0], rl0};
        drive(0, 0, 0, 0, 0); rl_seq = {rl_seq[4:0], rl0};
        drive(0, 0, 0, 0, 1); rl_seq = {rl_seq[4:0], rl0};
        drive(0, 0, 0, 0, 0); rl_seq = {rl_seq[4:0], rl0};
        drive(0, 0, 0, 0, 0); rl_seq = {rl_seq[4:0], rl0};
        tests_run++;
        if (rl_seq !== 6'b000010) begin
            fails++;
            $display("FAIL lost_delay_pulse got %b exp 000010", rl_seq);
        end
        tests_run++;
        if ({sc0, pause0, lives0} !== {3'd1, 1'b1, 3'd2}) begin
            fails++;
            $display("FAIL lost_to_ready got st=%0d p=%b lv=%0d exp st=1 p=1 lv=2", sc0, pause0, lives0);
        end
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic test_game_over();
        int pulses;
        lose_ball(pulses);
        tests_run++;
        if ({pulses[3:0], sc0, lives0} !== {4'd1, 3'd1, 3'd1}) begin
            fails++;
            $display("FAIL second_ball got pulses=%0d st=%0d lv=%0d exp pulses=1 st=1 lv=1", pulses, sc0, lives0);
        end
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        lose_ball(pulses);
        tests_run++;
        if ({pulses[3:0], sc0, go0, pause0, lives0, score0} !== {4'd0, 3'd5, 1'b1, 1'b1, 3'd0, bcd_of(hits)}) begin
            fails++;
            $display("FAIL game_over got pulses=%0d st=%0d go=%b p=%b lv=%0d sc=%h exp pulses=0 st=5 go=1 p=1 lv=0 sc=%h",
                     pulses, sc0, go0, pause0, lives0, score0, bcd_of(hits));
        end
        drive(1, 0, 0, 0, 0);
        pulses = int'(rl0);
        drive(0, 0, 0, 0, 0);
        tests_run++;
        if ({pulses[0], sc0, go0, score0} !== {1'b0, 3'd0, 1'b0, bcd_of(hits)}) begin
            fails++;
            $display("FAIL over_to_idle got rl=%0d st=%0d go=%b sc=%h exp rl=0 st=0 go=0 sc=%h",
                     pulses, sc0, go0, score0, bcd_of(hits));
        end
        drive(1, 0, 0, 0, 0);
        pulses = int'(rl0);
        drive(0, 0, 0, 0, 0);
        hits = 0;
        tests_run++;
        if ({pulses[0], sc0, lives0, score0, score5, score9} !== {1'b1, 3'd1, 3'd3, 48'h0}) begin
            fails++;
            $display("FAIL new_game got rl=%0d st=%0d lv=%0d sc=%h/%h/%h exp rl=1 st=1 lv=3 sc=0",
                     pulses, sc0, lives0, score0, score5, score9);
        end
    endtask

    task automatic test_pause_reset();
        exp_t e;
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        do_hit(1'b1);
        e = sb.pop_front();
        tests_run++;
        if ({score0, score5, score9} !== e) begin
            fails++;
            $display("FAIL second_game_hit got %h/%h/%h exp %h/%h/%h", score0, score5, score9, e.s0, e.s5, e.s9);
        end
        drive(0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0);
        tests_run++;
        if ({sc0, pause0, lives0, score0} !== {3'd3, 1'b1, 3'd3, bcd_of(hits)}) begin
            fails++;
            $display("FAIL paused_ignores got st=%0d p=%b lv=%0d sc=%h exp st=3 p=1 lv=3 sc=%h",
                     sc0, pause0, lives0, score0, bcd_of(hits));
        end
        drive(0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        tests_run++;
        if ({sc0, pause0} !== {3'd2, 1'b0}) begin
            fails++;
            $display("FAIL unpause got st=%0d p=%b exp st=2 p=0", sc0, pause0);
        end
        drive(0, 1, 1, 0, 0);
        drive(0, 0, 0, 0, 0);
        tests_run++;
        if ({sc0, lives0} !== {3'd4, 3'd2}) begin
            fails++;
            $display("FAIL keyp_with_bottom got st=%0d lv=%0d exp st=4 lv=2", sc0, lives0);
        end
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        tests_run++;
        if (sc0 !== 3'd3) begin
            fails++;
            $display("FAIL paused_before_reset got st=%0d exp 3", sc0);
        end
        resetN = 1'b0;
        #1;
        tests_run++;
        if ({sc0, pause0, rl0, lives0, go0, score0} !== {3'd0, 1'b1, 1'b0, 3'd3, 1'b0, 16'h0}) begin
            fails++;
            $display("FAIL async_reset got st=%0d p=%b rl=%b lv=%0d go=%b sc=%h exp st=0 p=1 rl=0 lv=3 go=0 sc=0000",
                     sc0, pause0, rl0, lives0, go0, score0);
        end
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        resetN = 1'b1;
        drive(0, 0, 0, 0, 0);
        tests_run++;
        if ({sc0, rl0, lives0} !== {3'd0, 1'b0, 3'd3}) begin
            fails++;
            $display("FAIL after_reset got st=%0d rl=%b lv=%0d exp st=0 rl=0 lv=3", sc0, rl0, lives0);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_scoring();
        test_ball_lost();
        test_game_over();
        test_pause_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
